mem_access_unit: RTL

Memory stage of the RISC-V core. It consumes the effective address, ALU op, and store operand that the execute stage produces for loads and stores, and performs the access over the byte-wide memory port. Each access is a sequence of one-byte request/acknowledge transactions. It stalls the pipeline until the access completes, then hands load data and writeback control to the writeback stage. Non-memory instructions pass through with no stall.

---
 rtl/mem_access_unit_if.sv | 45 ++++
 rtl/mem_access_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: the byte-wide memory port.
// Each byte moves in one request/acknowledge transaction.
//   master (the memory stage): drives mem_req, mem_we, mem_addr_o, mem_wdata
//   slave  (the memory):       drives mem_rdata, mem_ack
// The bus width and opcode macros are shared with the design and any
// environment. Each definition is guarded, so every file can declare them.

`ifndef AluOpBus
`define AluOpBus   7:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'h20
`define EXE_LH_OP  8'h21
`define EXE_LW_OP  8'h23
`define EXE_LBU_OP 8'h24
`define EXE_LHU_OP 8'h25
`define EXE_SB_OP  8'h28
`define EXE_SH_OP  8'h29
`define EXE_SW_OP  8'h2B
`define EXE_ADD_OP 8'h01
`endif

interface mem_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr_o, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr_o, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the RISC-V core.
// Loads and stores run as a sequence of little-endian byte transactions
// on mem_bus. While an access is in progress, the unit stalls the pipeline.
// When the access ends, the unit hands the load result and the writeback
// control to the writeback stage. Non-memory ops pass straight through.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   aluop_i                   op; selects LB/LH/LW/LBU/LHU/SB/SH/SW or non-memory
//   mem_addr_i, rt_data_i     effective byte address, store operand
//   reg_waddr_i, we_i,
//   reg_wdata_i               writeback control/data from execute
//   reg_waddr_o, we_o,
//   reg_wdata_o               writeback control/data to writeback
//   stallreq                  stall upstream; inputs held stable while high
//   mem_bus (master)          byte request/acknowledge port
//   misalign                  misaligned-access flag (MEM_MISALIGN_CHECK_EN only)
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to enable it. Misaligned
// half and word accesses then skip the memory port, and misalign is raised
// in the DONE cycle.
//
// state | meaning
// IDLE  | pass-through; a memory op starts an access
// BUSY  | byte idx_q in flight, waiting for mem_ack
// DONE  | one cycle; present the load result, release the stall

`ifndef AluOpBus
`define AluOpBus   7:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'h20
`define EXE_LH_OP  8'h21
`define EXE_LW_OP  8'h23
`define EXE_LBU_OP 8'h24
`define EXE_LHU_OP 8'h25
`define EXE_SB_OP  8'h28
`define EXE_SH_OP  8'h29
`define EXE_SW_OP  8'h2B
`define EXE_ADD_OP 8'h01
`endif

module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [`AluOpBus]   aluop_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [31:0]        rt_data_i,
    input  logic [`RegAddrBus] reg_waddr_i,
    input  logic               we_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [`RegAddrBus] reg_waddr_o,
    output logic               we_o,
    output logic [31:0]        reg_wdata_o,
    output logic               stallreq,
    mem_access_unit_if.master  mem_bus
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic               misalign
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] buf_q, buf_d;

    logic        is_load, is_store, is_mem;
    logic [1:0]  last_idx;
    logic [31:0] load_ext;
    logic        skip_access;

    // Decode the memory class and the index of the final byte
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        last_idx = 2'd0;
        load_ext = buf_q;
        case (aluop_i)
            `EXE_LB_OP:  begin is_load  = 1'b1; load_ext = {{24{buf_q[7]}}, buf_q[7:0]}; end
            `EXE_LBU_OP: begin is_load  = 1'b1; load_ext = {24'd0, buf_q[7:0]}; end
            `EXE_LH_OP:  begin is_load  = 1'b1; last_idx = 2'd1; load_ext = {{16{buf_q[15]}}, buf_q[15:0]}; end
            `EXE_LHU_OP: begin is_load  = 1'b1; last_idx = 2'd1; load_ext = {16'd0, buf_q[15:0]}; end
            `EXE_LW_OP:  begin is_load  = 1'b1; last_idx = 2'd3; end
            `EXE_SB_OP:  begin is_store = 1'b1; end
            `EXE_SH_OP:  begin is_store = 1'b1; last_idx = 2'd1; end
            `EXE_SW_OP:  begin is_store = 1'b1; last_idx = 2'd3; end
            default: ;
        endcase
        is_mem = is_load | is_store;
    end

    // Inputs are held stable through DONE, so the alignment check needs no
    // register. The same check marks the DONE cycle of a skipped access.
`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        skip_access = 1'b0;
        if (last_idx == 2'd1)
            skip_access = mem_addr_i[0];
        else if (last_idx == 2'd3)
            skip_access = (mem_addr_i[1:0] != 2'b00);
    end
`else
    assign skip_access = 1'b0;
`endif

    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        buf_d               = buf_q;
        stallreq            = 1'b0;
        we_o                = 1'b0;
        reg_waddr_o         = '0;
        reg_wdata_o         = '0;
        mem_bus.mem_req     = 1'b0;
        mem_bus.mem_we      = 1'b0;
        mem_bus.mem_addr_o  = '0;
        mem_bus.mem_wdata   = '0;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign            = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    stallreq = 1'b1;
                    idx_d    = 2'd0;
                    buf_d    = '0;
                    state_d  = skip_access ? DONE : BUSY;
                end else begin
                    reg_waddr_o = reg_waddr_i;
                    we_o        = we_i;
                    reg_wdata_o = reg_wdata_i;
                end
            end
            BUSY: begin
                stallreq           = 1'b1;
                mem_bus.mem_req    = 1'b1;
                mem_bus.mem_we     = is_store;
                mem_bus.mem_addr_o = mem_addr_i + ADDR_W'(idx_q);
                mem_bus.mem_wdata  = rt_data_i[{idx_q, 3'b000} +: 8];
                if (mem_bus.mem_ack) begin
                    if (is_load)
                        buf_d[{idx_q, 3'b000} +: 8] = mem_bus.mem_rdata;
                    if (idx_q == last_idx)
                        state_d = DONE;
                    else
                        idx_d = idx_q + 2'd1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                reg_waddr_o = reg_waddr_i;
                if (skip_access) begin
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign = 1'b1;
`endif
                end else if (is_load) begin
                    we_o        = we_i;
                    reg_wdata_o = load_ext;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset overrides every output in the same cycle
        if (rst) begin
            stallreq           = 1'b0;
            we_o               = 1'b0;
            reg_waddr_o        = '0;
            reg_wdata_o        = '0;
            mem_bus.mem_req    = 1'b0;
            mem_bus.mem_we     = 1'b0;
            mem_bus.mem_addr_o = '0;
            mem_bus.mem_wdata  = '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign           = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

endmodule
